// File: rtl/etc_lane_ctrl.sv
// etc_lane_ctrl
// Non-stop ETC lane controller. It does three jobs:
//   * Counts the vehicles between the entry sensor and the exit sensor.
//     Each vehicle also gets an E-pass verdict, held in a 1-bit FIFO.
//   * Measures the time from sensor1 to sensor2 in ms. It then turns that
//     time into km/h with a sequential restoring divider and flags overspeed.
//   * Drives the barrier. The barrier opens for a valid head vehicle, for a
//     programmable hold time after each exit, or by maintenance override.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       maintenance override, forces barrier open
//   sensor1      entry sensor (level)
//   sensor2      speed-trap sensor (level)
//   sensor3      exit sensor, past barrier (level)
//   valid_Epass  reader verdict, 2'b01 = valid, anything else = invalid
//   speed        last measured speed in km/h
//   done         one-cycle pulse when speed is updated
//   overspeed    updated together with done, 1 if speed > SPEED_LIMIT
//   timeout      one-cycle pulse when the ms timer saturates while timing
//   num_veh      vehicles currently between sensor1 and sensor3
//   overflow     sticky, set on an entry into a full queue
//   barrier      1 = open
module etc_lane_ctrl #(
  parameter int SYS_FREQ    = 50000000,
  parameter int WIDTH_MS    = 14,
  parameter int WIDTH_SPEED = 14,
  parameter int DIST_MM     = 5000,
  parameter int SPEED_LIMIT = 60,
  parameter int QDEPTH      = 4,
  parameter int BARRIER_MS  = 2000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sensor1,
  input  logic                         sensor2,
  input  logic                         sensor3,
  input  logic [1:0]                   valid_Epass,
  output logic [WIDTH_SPEED-1:0]       speed,
  output logic                         done,
  output logic                         overspeed,
  output logic                         timeout,
  output logic [$clog2(QDEPTH+1)-1:0]  num_veh,
  output logic                         overflow,
  output logic                         barrier
);

  localparam int TICK  = SYS_FREQ / 1000;
  localparam int TW    = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int K_VAL = DIST_MM * 36 / 10;
  localparam int KW    = $clog2(K_VAL + 1);
  localparam int DW    = ((KW > WIDTH_MS + WIDTH_SPEED) ? KW : (WIDTH_MS + WIDTH_SPEED)) + 1;
  localparam int BCW   = $clog2(WIDTH_SPEED + 1);
  localparam int NVW   = $clog2(QDEPTH + 1);
  localparam int PW    = $clog2(QDEPTH);
  localparam int HW    = $clog2(BARRIER_MS + 1);

  localparam logic [TW-1:0]          TICK_LAST = TW'(TICK - 1);
  localparam logic [WIDTH_MS-1:0]    MS_MAX    = '1;
  localparam logic [WIDTH_MS-1:0]    MS_ONE    = WIDTH_MS'(1);
  localparam logic [DW-1:0]          K_NUM     = DW'(K_VAL);
  localparam logic [BCW-1:0]         BIT_LAST  = BCW'(WIDTH_SPEED - 1);
  localparam logic [WIDTH_SPEED-1:0] LIMIT     = WIDTH_SPEED'(SPEED_LIMIT);
  localparam logic [NVW-1:0]         Q_FULL    = NVW'(QDEPTH);
  localparam logic [NVW-1:0]         NV_ONE    = NVW'(1);
  localparam logic [PW-1:0]          PTR_ONE   = PW'(1);
  localparam logic [HW-1:0]          HOLD_LOAD = HW'(BARRIER_MS);
  localparam logic [HW-1:0]          HOLD_ONE  = HW'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TIMING = 2'd1;
  localparam logic [1:0] DIVIDE = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;

  // When K/divisor does not fit in WIDTH_SPEED bits, return the all-ones value.
  function automatic logic [WIDTH_SPEED-1:0] sat_quotient(input logic [WIDTH_SPEED-1:0] q,
                                                          input logic ovf);
    return ovf ? '1 : q;
  endfunction

  // ---- Stage p0/p1: sensor sampling and rising-edge detection ----
  logic [2:0] sens_p0, sens_p1;
  logic       rise1, rise2, rise3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sens_p0 <= '0;
      sens_p1 <= '0;
    end else begin
      sens_p0 <= {sensor3, sensor2, sensor1};
      sens_p1 <= sens_p0;
    end
  end

  assign rise1 = sens_p0[0] & ~sens_p1[0];
  assign rise2 = sens_p0[1] & ~sens_p1[1];
  assign rise3 = sens_p0[2] & ~sens_p1[2];

  // Free-running 1 ms tick.
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // ---- Speed FSM and restoring divider ----
  logic [1:0]             state;
  logic [WIDTH_MS-1:0]    ms_cnt, divisor;
  logic [BCW-1:0]         bit_cnt;
  logic [DW-1:0]          rem_p0, dsh_p0;
  logic [WIDTH_SPEED-1:0] quo_p0, result;
  logic                   ovf_p0, start_div, step_take;

  assign divisor   = (ms_cnt == '0) ? MS_ONE : ms_cnt;
  assign start_div = (state == TIMING) && rise2;
  assign step_take = (rem_p0 >= dsh_p0);
  assign result    = sat_quotient(quo_p0, ovf_p0);

  // The shifted divisor starts at divisor << (WIDTH_SPEED-1). Each cycle it
  // moves one bit right, giving one quotient bit from MSB to LSB. Overflow is
  // decided up front: K >= divisor << WIDTH_SPEED means the quotient cannot fit.
  always_ff @(posedge clk) begin
    if (start_div) begin
      rem_p0 <= K_NUM;
      dsh_p0 <= DW'(divisor) << (WIDTH_SPEED - 1);
      quo_p0 <= '0;
      ovf_p0 <= (K_NUM >= (DW'(divisor) << WIDTH_SPEED));
    end else if (state == DIVIDE) begin
      if (step_take) rem_p0 <= rem_p0 - dsh_p0;
      dsh_p0 <= dsh_p0 >> 1;
      quo_p0 <= {quo_p0[WIDTH_SPEED-2:0], step_take};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ms_cnt    <= '0;
      bit_cnt   <= '0;
      speed     <= '0;
      done      <= 1'b0;
      overspeed <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rise1) begin
            state  <= TIMING;
            ms_cnt <= '0;
          end
        end
        TIMING: begin
          // A sensor2 rise wins over a tick in the same cycle.
          if (rise2) begin
            state   <= DIVIDE;
            bit_cnt <= '0;
          end else if (tick) begin
            if (ms_cnt == MS_MAX - MS_ONE) begin
              ms_cnt  <= MS_MAX;
              timeout <= 1'b1;
              state   <= IDLE;
            end else begin
              ms_cnt <= ms_cnt + MS_ONE;
            end
          end
        end
        DIVIDE: begin
          bit_cnt <= bit_cnt + BCW'(1);
          if (bit_cnt == BIT_LAST) state <= RESULT;
        end
        RESULT: begin
          speed     <= result;
          done      <= 1'b1;
          overspeed <= (result > LIMIT);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- Vehicle / verdict queue and barrier ----
  logic            qmem [QDEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr, rd_next;
  logic [HW-1:0]   hold_cnt, hold_next;
  logic [NVW-1:0]  nv_next;
  logic            verdict, q_full, do_pop, do_push, old_left, head_next, barrier_next;

  // The barrier register loads the post-event state, so it reacts to a push,
  // a pop, or an enable change one cycle after the event.
  always_comb begin
    verdict   = (valid_Epass == 2'b01);
    q_full    = (num_veh == Q_FULL);
    do_pop    = rise3 && (num_veh != '0);
    do_push   = rise1 && (!q_full || do_pop);
    rd_next   = do_pop ? rd_ptr + PTR_ONE : rd_ptr;
    nv_next   = num_veh;
    if (do_push && !do_pop)      nv_next = num_veh + NV_ONE;
    else if (do_pop && !do_push) nv_next = num_veh - NV_ONE;
    // If an older entry survives the pop, it is the new head. Otherwise the
    // head is the entry being pushed this cycle, if there is one.
    old_left  = do_pop ? (num_veh != NV_ONE) : (num_veh != '0);
    head_next = 1'b0;
    if (old_left)     head_next = qmem[rd_next];
    else if (do_push) head_next = verdict;
    hold_next = hold_cnt;
    if (do_pop)                            hold_next = HOLD_LOAD;
    else if (tick && (hold_cnt != '0))     hold_next = hold_cnt - HOLD_ONE;
    barrier_next = enable || (hold_next != '0) || head_next;
  end

  always_ff @(posedge clk) begin
    if (do_push) qmem[wr_ptr] <= verdict;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      num_veh  <= '0;
      overflow <= 1'b0;
      hold_cnt <= '0;
      barrier  <= 1'b0;
    end else begin
      rd_ptr   <= rd_next;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      num_veh  <= nv_next;
      if (rise1 && !do_push) overflow <= 1'b1;
      hold_cnt <= hold_next;
      barrier  <= barrier_next;
    end
  end

endmodule

// File: doc/etc_lane_ctrl.md
Name: etc_lane_ctrl

Overview:
Next-generation non-stop ETC lane controller. It counts vehicles in the toll zone and keeps a per-vehicle E-pass verdict queue of parametrised depth. It measures speed between sensor1 and sensor2 with a sequential divider and flags overspeed. It drives the barrier with a programmable hold time, sitting between the lane sensor/reader front-end and the lane supervisor.

Parameters:
SYS_FREQ, 50000000, clk frequency in Hz; ms tick period = SYS_FREQ/1000 clk
WIDTH_MS, 14, ms timer width; saturates at 2^WIDTH_MS-1
WIDTH_SPEED, 14, speed result width in km/h
DIST_MM, 5000, sensor1-to-sensor2 spacing in mm; numerator K = DIST_MM*36/10 (localparam)
SPEED_LIMIT, 60, overspeed threshold in km/h, strict greater-than
QDEPTH, 4, vehicle/E-pass queue depth, power of two, >= 2
BARRIER_MS, 2000, barrier hold time in ms after a vehicle exits

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  maintenance override; forces barrier=1
sensor1  input  1  entry sensor, level, synchronous/debounced
sensor2  input  1  speed-trap sensor
sensor3  input  1  exit sensor, past barrier
valid_Epass  input  2  reader verdict: 01 valid, 10 invalid, 00/11 treated as invalid
speed  output  WIDTH_SPEED  last measured speed, km/h
done  output  1  one-cycle pulse when speed is updated
overspeed  output  1  registered with done; 1 if speed > SPEED_LIMIT
timeout  output  1  one-cycle pulse when the ms timer saturates
num_veh  output  $clog2(QDEPTH+1)  vehicles between sensor1 and sensor3
overflow  output  1  sticky; set on push into a full queue, cleared by reset only
barrier  output  1  1 = open

Behaviour:
- Reset (asynchronous): all outputs 0, FSM IDLE, queue empty, all counters 0.
- Edge detect: each sensor is registered once; a rise is the cycle where the sample is 1 and the previous sample is 0.
- ms tick: counter 0..SYS_FREQ/1000-1; one-cycle tick at wrap; free-running from reset.
- Speed FSM: IDLE, TIMING, DIVIDE, RESULT.
  - IDLE -> TIMING on sensor1 rise; ms counter cleared to 0.
  - TIMING: ms counter +1 per tick. A sensor1 rise here is ignored for timing.
  - TIMING -> DIVIDE on sensor2 rise; divisor = max(ms,1).
  - TIMING -> IDLE if ms reaches max. Pulse timeout that cycle; speed unchanged; no done.
  - DIVIDE: restoring divide K/divisor, one quotient bit per clk, exactly WIDTH_SPEED cycles. Quotient saturates at 2^WIDTH_SPEED-1 if K/divisor overflows.
  - RESULT (1 cycle): load speed, pulse done, set overspeed = (quotient > SPEED_LIMIT); then -> IDLE.
  - Latency: done is high exactly WIDTH_SPEED+2 clk after the first cycle sensor2 is sampled high.
  - A sensor2 rise in IDLE, DIVIDE or RESULT is ignored.
- Queue: 1-bit FIFO of depth QDEPTH holding verdict = (valid_Epass==2'b01), sampled at the sensor1 rise cycle.
  - Push on sensor1 rise; pop on sensor3 rise. num_veh tracks occupancy.
  - Simultaneous push and pop: both occur, num_veh unchanged. If the queue is full, the pop frees the slot and the push succeeds.
  - Push when full (no pop): dropped, overflow set.
  - Pop when empty: ignored; num_veh stays 0.
- Barrier: open = enable | hold_active | (queue non-empty & head verdict == 1).
  - Each successful pop (re)loads the hold counter with BARRIER_MS. It decrements per tick; hold_active while it is non-zero.
  - Hold counter reload mid-hold restarts the full BARRIER_MS.
  - Invalid head with no hold active and enable=0: barrier=0.
  - enable does not affect the queue, FSM or counters.
- Barrier and done are registered outputs; barrier updates the cycle after the causing event.

Test Plan:
1. SYS_FREQ=4000 (tick every 4 clk), DIST_MM=5000 (K=18000): sensor1 rise, sensor2 rise 300 ticks later -> speed=60, done 1 cycle at WIDTH_SPEED+2 clk after sensor2 sampled high, overspeed=0.
2. Same setup, sensor2 rise 200 ticks after sensor1 -> speed=90, overspeed=1. Then sensor2 rise with FSM in IDLE -> no done.
3. sensor1 rise with no sensor2 for 2^WIDTH_MS ticks -> timeout pulse, speed keeps its previous value, FSM returns to IDLE.
4. QDEPTH=4: 5 sensor1 rises with valid_Epass=01 -> num_veh=4, overflow=1, barrier=1. Four sensor3 rises -> num_veh=0; barrier stays 1 for BARRIER_MS ticks after the last pop, then 0.
5. Queue holding [invalid, valid]: barrier=0. sensor3 rise -> head becomes valid, barrier=1 next cycle. Simultaneous sensor1/sensor3 rise -> num_veh unchanged.
6. Assert reset mid-DIVIDE with 2 vehicles queued and barrier open -> immediately speed=0, num_veh=0, barrier=0, done=0, overflow=0; enable=1 after release -> barrier=1.
